config_tile_responder: RTL and testbench

- Tile-side responder for the global configuration bus that drives config_addr/config_data into the CGRA top.
- One instance per tile/feature.
- Decodes each bus transaction against its own tile and feature ID, stores matching writes in a local register file that feeds the tile fabric, and answers readback requests.
- Tracks configuration progress and flags when the bus has gone quiet after configuration.

---
 rtl/config_tile_responder.sv | 175 +++++++++++++++++
 tb/tb_config_tile_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_tile_responder.sv
// Tile-side configuration bus responder: address decode, local register file,
// readback with fixed two-edge latency, and post-configuration idle detection.
module config_tile_responder #(
    parameter logic [15:0] TILE_ID      = 16'h0015,
    parameter logic [7:0]  FEATURE_ID   = 8'h00,
    parameter int          NUM_REGS     = 8,
    parameter int          IDLE_TIMEOUT = 16
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [31:0]              config_addr_in,
    input  logic [31:0]              config_data_in,
    input  logic                     config_valid_in,
    input  logic                     config_read_in,
    output logic [31:0]              read_data_out,
    output logic                     read_valid_out,
    output logic [NUM_REGS*32-1:0]   cfg_regs_out,
    output logic                     config_done_out,
    output logic [15:0]              write_count_out
);

    localparam int IDW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        CONFIG = 2'd1,
        DONE   = 2'd2
    } state_e;

    logic [31:0]            cap_addr_q, cap_addr_d;
    logic [31:0]            cap_data_q, cap_data_d;
    logic                   cap_valid_q, cap_valid_d;
    logic                   cap_read_q, cap_read_d;

    logic [NUM_REGS*32-1:0] regs_q, regs_d;
    logic [31:0]            read_data_q, read_data_d;
    logic                   read_valid_q, read_valid_d;
    logic [15:0]            wcount_q, wcount_d;
    state_e                 state_q, state_d;
    logic [IDW-1:0]         idle_q, idle_d;
    logic                   done_q, done_d;

    logic [7:0]             idx_s;
    logic                   match_s;
    logic                   in_range_s;
    logic                   wr_acc_s;
    logic                   rd_hit_s;
    logic [31:0]            rd_word_s;

    // Stage 1 captures the bus every cycle; there is no backpressure.
    always_comb begin
        cap_addr_d  = config_addr_in;
        cap_data_d  = config_data_in;
        cap_valid_d = config_valid_in;
        cap_read_d  = config_read_in;
    end

    // Decode of the captured request against this tile's identity.
    always_comb begin
        idx_s      = cap_addr_q[31:24];
        match_s    = cap_valid_q && (cap_addr_q[15:0] == TILE_ID)
                     && (cap_addr_q[23:16] == FEATURE_ID);
        in_range_s = ({1'b0, idx_s} < 9'(NUM_REGS));
        wr_acc_s   = match_s && !cap_read_q && in_range_s;
        rd_hit_s   = match_s && cap_read_q;
    end

    // Register file update and OR-reduced readback mux (out-of-range reads give zero).
    always_comb begin
        regs_d    = regs_q;
        rd_word_s = 32'h0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[32*i +: 32] = (wr_acc_s && (idx_s == 8'(i))) ? cap_data_q
                                                                 : regs_q[32*i +: 32];
            rd_word_s = rd_word_s | ((idx_s == 8'(i)) ? regs_q[32*i +: 32] : 32'h0);
        end
    end

    // Readback response and saturating accepted-write counter.
    always_comb begin
        read_valid_d = rd_hit_s;
        read_data_d  = rd_hit_s ? rd_word_s : read_data_q;
        wcount_d     = (wr_acc_s && (wcount_q != 16'hFFFF)) ? (wcount_q + 16'd1) : wcount_q;
    end

    // Configuration progress: any non-accepting cycle counts as idle while configuring.
    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        case (state_q)
            UNCONF: begin
                if (wr_acc_s) begin
                    state_d = CONFIG;
                    idle_d  = '0;
                end else begin
                    idle_d  = '0;
                end
            end
            CONFIG: begin
                if (wr_acc_s) begin
                    idle_d = '0;
                end else if (idle_q == IDW'(IDLE_TIMEOUT - 1)) begin
                    idle_d  = IDW'(IDLE_TIMEOUT);
                    state_d = DONE;
                end else begin
                    idle_d = idle_q + IDW'(1);
                end
            end
            DONE: begin
                if (wr_acc_s) begin
                    state_d = CONFIG;
                    idle_d  = '0;
                end else begin
                    idle_d  = idle_q;
                end
            end
            default: begin
                state_d = UNCONF;
                idle_d  = '0;
            end
        endcase
        // Rises one edge after entering DONE, but drops on the very edge a new write lands.
        done_d = (state_q == DONE) && !wr_acc_s;
    end

    // Capture stage flops.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            cap_addr_q  <= 32'h0;
            cap_data_q  <= 32'h0;
            cap_valid_q <= 1'b0;
            cap_read_q  <= 1'b0;
        end else begin
            cap_addr_q  <= cap_addr_d;
            cap_data_q  <= cap_data_d;
            cap_valid_q <= cap_valid_d;
            cap_read_q  <= cap_read_d;
        end
    end

    // Register file, readback and counter flops.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            regs_q       <= '0;
            read_data_q  <= 32'h0;
            read_valid_q <= 1'b0;
            wcount_q     <= 16'h0;
        end else begin
            regs_q       <= regs_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            wcount_q     <= wcount_d;
        end
    end

    // Progress FSM state, idle counter and registered done flag.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= UNCONF;
            idle_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
        end
    end

    assign read_data_out   = read_data_q;
    assign read_valid_out  = read_valid_q;
    assign cfg_regs_out    = regs_q;
    assign config_done_out = done_q;
    assign write_count_out = wcount_q;

endmodule

// File: tb/tb_config_tile_responder.sv
// Randomized scoreboard bench for config_tile_responder: stimulus pushes timed
// expected events, a negedge monitor applies them and compares all outputs.
module tb_config_tile_responder;

    localparam int NREG = 8;
    localparam int IDLE = 16;

    logic               clk_in = 1'b0;
    logic               reset_in;
    logic [31:0]        config_addr_in;
    logic [31:0]        config_data_in;
    logic               config_valid_in;
    logic               config_read_in;
    logic [31:0]        read_data_out;
    logic               read_valid_out;
    logic [NREG*32-1:0] cfg_regs_out;
    logic               config_done_out;
    logic [15:0]        write_count_out;

    config_tile_responder #(
        .TILE_ID(16'h0015), .FEATURE_ID(8'h00), .NUM_REGS(NREG), .IDLE_TIMEOUT(IDLE)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .config_addr_in  (config_addr_in),
        .config_data_in  (config_data_in),
        .config_valid_in (config_valid_in),
        .config_read_in  (config_read_in),
        .read_data_out   (read_data_out),
        .read_valid_out  (read_valid_out),
        .cfg_regs_out    (cfg_regs_out),
        .config_done_out (config_done_out),
        .write_count_out (write_count_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          at;
        bit          rd;
        int          idx;
        logic [31:0] data;
    } ev_t;

    ev_t                evq[$];
    ev_t                ev;
    int                 edge_cnt = 0;
    int                 checks   = 0;
    int                 errors   = 0;
    bit                 mon_en   = 1'b0;

    // Issue-time model (what a read will return) and visible-state model.
    logic [31:0]        m_regs [NREG];
    logic [NREG*32-1:0] v_regs;
    logic [31:0]        v_rdata;
    logic [15:0]        v_count;
    bit                 has_acc;
    int                 last_acc;
    bit                 exp_rv;

    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", nm, edge_cnt, act, exp);
        end
    endtask

    task automatic clear_model();
        evq.delete();
        for (int i = 0; i < NREG; i++) m_regs[i] = 32'h0;
        v_regs   = '0;
        v_rdata  = 32'h0;
        v_count  = 16'h0;
        has_acc  = 1'b0;
        last_acc = 0;
    endtask

    // Drive one bus cycle; expected effects land two edges later.
    task automatic drive(input bit v, input bit rd, input logic [31:0] a, input logic [31:0] d);
        int          idx;
        logic [31:0] rv;
        config_valid_in = v;
        config_read_in  = rd;
        config_addr_in  = a;
        config_data_in  = d;
        idx = int'(a[31:24]);
        if (v && a[15:0] == 16'h0015 && a[23:16] == 8'h00) begin
            if (rd) begin
                rv = 32'h0;
                if (idx < NREG) rv = m_regs[idx];
                evq.push_back('{edge_cnt + 2, 1'b1, idx, rv});
            end else if (idx < NREG) begin
                m_regs[idx] = d;
                evq.push_back('{edge_cnt + 2, 1'b0, idx, d});
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] mk(input int idx, input logic [7:0] feat, input logic [15:0] tile);
        logic [7:0] ib;
        ib = 8'(idx);
        return {ib, feat, tile};
    endfunction

    // Monitor: retire due events into the visible model, then compare every output.
    always @(negedge clk_in) begin
        if (mon_en) begin
            exp_rv = 1'b0;
            while (evq.size() > 0 && evq[0].at <= edge_cnt) begin
                ev = evq.pop_front();
                if (ev.rd) begin
                    exp_rv  = 1'b1;
                    v_rdata = ev.data;
                end else begin
                    v_regs[ev.idx*32 +: 32] = ev.data;
                    if (v_count != 16'hFFFF) v_count = v_count + 16'd1;
                    has_acc  = 1'b1;
                    last_acc = ev.at;
                end
            end
            chk("read_valid",  {255'b0, read_valid_out}, {255'b0, exp_rv});
            chk("read_data",   {224'b0, read_data_out}, {224'b0, v_rdata});
            chk("cfg_regs",    cfg_regs_out, v_regs);
            chk("write_count", {240'b0, write_count_out}, {240'b0, v_count});
            chk("config_done", {255'b0, config_done_out},
                {255'b0, (has_acc && (edge_cnt - last_acc) >= IDLE + 1)});
        end
    end

    task automatic async_reset_check();
        reset_in = 1'b0;
        #1;
        chk("rst_read_valid",  {255'b0, read_valid_out}, 256'h0);
        chk("rst_read_data",   {224'b0, read_data_out}, 256'h0);
        chk("rst_cfg_regs",    cfg_regs_out, 256'h0);
        chk("rst_write_count", {240'b0, write_count_out}, 256'h0);
        chk("rst_config_done", {255'b0, config_done_out}, 256'h0);
        clear_model();
        config_valid_in = 1'b0;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        reset_in = 1'b1;
    endtask

    initial begin
        int kind;
        logic [7:0]  feat;
        logic [15:0] tile;
        clear_model();
        config_addr_in  = 32'h0;
        config_data_in  = 32'h0;
        config_valid_in = 1'b0;
        config_read_in  = 1'b0;
        reset_in        = 1'b1;
        #1 reset_in     = 1'b0;
        #20;
        @(posedge clk_in); #1;
        reset_in = 1'b1;
        mon_en   = 1'b1;

        // Basic write, readback, out-of-range read
        drive(1'b1, 1'b0, 32'h0300_0015, 32'h1234_5678);
        drive(1'b1, 1'b0, 32'h0500_0015, 32'hCAFE_F00D);
        drive(1'b1, 1'b1, 32'h0500_0015, 32'h0);
        drive(1'b1, 1'b1, 32'h0800_0015, 32'h0);
        drive(1'b1, 1'b1, 32'h0300_0015, 32'h0);
        // Address filtering
        drive(1'b1, 1'b0, 32'h0100_0016, 32'hDEAD_0001);
        drive(1'b1, 1'b0, 32'h0101_0015, 32'hDEAD_0002);
        drive(1'b1, 1'b1, 32'h0500_0016, 32'h0);
        drive(1'b1, 1'b0, 32'h0800_0015, 32'hDEAD_0003);
        idle(3);

        // Done detection with interleaved reads, then re-arm with a new write
        drive(1'b1, 1'b0, 32'h0000_0015, 32'h0000_00A0);
        drive(1'b1, 1'b0, 32'h0100_0015, 32'h0000_00A1);
        drive(1'b1, 1'b0, 32'h0200_0015, 32'h0000_00A2);
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b1, mk(i % 9, 8'h00, 16'h0015), 32'h0);
            idle(1);
        end
        drive(1'b1, 1'b0, 32'h0400_0015, 32'h0000_00B4);
        idle(22);

        // Randomized traffic with occasional quiet gaps
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 299) idle(IDLE + 3);
            kind = int'($urandom_range(0, 9));
            feat = (kind == 1) ? 8'h01 : 8'h00;
            tile = (kind == 0) ? 16'h0016 : 16'h0015;
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                  mk(int'($urandom_range(0, 9)), feat, tile), $urandom);
        end
        idle(IDLE + 4);

        // Reset while a write to reg 2 sits in stage 1 and done is high
        chk("done_before_reset", {255'b0, config_done_out}, 256'h1);
        drive(1'b1, 1'b0, 32'h0200_0015, 32'h5555_AAAA);
        #1;
        async_reset_check();
        idle(IDLE + 6);

        // Reconfigure and stream past counter saturation
        for (int i = 0; i < 70000; i++)
            drive(1'b1, 1'b0, mk(i % NREG, 8'h00, 16'h0015), 32'(i));
        idle(4);
        chk("sat_count", {240'b0, write_count_out}, 256'h0000_FFFF);
        for (int i = 0; i < NREG; i++)
            drive(1'b1, 1'b1, mk(i, 8'h00, 16'h0015), 32'h0);
        idle(4);
        chk("events_drained", 256'(evq.size()), 256'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
